// File: rtl/sdr_fmt_pkg.sv
// Shared output-format encodings for the sample format converter.
package sdr_fmt_pkg;

    typedef enum logic [1:0] {
        FMT_OFFSET = 2'd0,
        FMT_TWOS   = 2'd1,
        FMT_MAG    = 2'd2,
        FMT_RSVD   = 2'd3
    } fmt_mode_e;

endpackage

// File: rtl/sample_format_converter_if.sv
// Valid/ready sample stream bundle with producer and consumer views.
interface sample_format_converter_if #(
    parameter int W = 16
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fmt_lane.sv
// One sample lane: S1 rounds and saturates to OUT_WIDTH, S2 applies the format map.
module fmt_lane
    import sdr_fmt_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load1,
    input  logic                 load2,
    input  logic [IN_WIDTH-1:0]  sample,
    input  fmt_mode_e            mode,
    output logic                 clip,
    output logic [OUT_WIDTH-1:0] data
);

    localparam int D = IN_WIDTH - OUT_WIDTH;
    localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};

    logic [OUT_WIDTH-1:0] rounded;
    logic                 over;
    logic [OUT_WIDTH-1:0] s1_value;
    logic                 s1_clip;
    logic [OUT_WIDTH-1:0] mapped;

    if (D > 0) begin : g_round
        localparam logic signed [IN_WIDTH:0] HALF     = (IN_WIDTH+1)'(1) << (D-1);
        localparam logic signed [IN_WIDTH:0] MAX_WIDE = (IN_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
        logic signed [IN_WIDTH:0] biased;
        logic signed [IN_WIDTH:0] shifted;

        // One extra bit keeps the half-LSB bias from wrapping the largest input.
        assign biased  = $signed({sample[IN_WIDTH-1], sample}) + HALF;
        assign shifted = biased >>> D;
        assign over    = shifted > MAX_WIDE;
        assign rounded = over ? MAX_POS : shifted[OUT_WIDTH-1:0];
    end else begin : g_pass
        assign over    = 1'b0;
        assign rounded = sample;
    end

    // NOTE: datapath registers carry no reset; the valid bits in the top decide whether they mean anything.
    always_ff @(posedge clk) begin
        if (load1) begin
            s1_value <= rounded;
            s1_clip  <= over;
        end
    end

    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
    always_comb begin
        mapped = s1_value;
        case (mode)
            FMT_TWOS: mapped = s1_value;
            FMT_MAG:  mapped = s1_value[OUT_WIDTH-1] ? -s1_value : s1_value;
            default:  mapped = {~s1_value[OUT_WIDTH-1], s1_value[OUT_WIDTH-2:0]};
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (load2) begin
            data <= mapped;
        end
    end

    assign clip = s1_clip;

endmodule

// File: rtl/sample_format_converter.sv
// Two-stage valid/ready sample converter: round/saturate, then format map, with sticky clip flags and a clip counter.
module sample_format_converter
    import sdr_fmt_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [CHANNELS*IN_WIDTH-1:0]  i_data,
    input  logic [1:0]                    i_mode,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [CHANNELS*OUT_WIDTH-1:0] o_data,
    output logic [CHANNELS-1:0]           o_clip,
    input  logic                          i_clear_clip,
    output logic [CNT_WIDTH-1:0]          o_clip_count
);

    logic                en1;
    logic                en2;
    logic                load1;
    logic                load2;
    logic                s1_valid;
    fmt_mode_e           s1_mode;
    logic [CHANNELS-1:0] s1_clip;

    assign en2     = i_ready | ~o_valid;
    assign en1     = en2 | ~s1_valid;
    assign o_ready = en1;
    assign load1   = en1 & i_valid;
    assign load2   = en2 & s1_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            if (en1) s1_valid <= i_valid;
            if (en2) o_valid  <= s1_valid;
        end
    end

    // The mode travels with its beat so a mid-stream change only affects later beats.
    always_ff @(posedge i_clk) begin
        if (load1) s1_mode <= fmt_mode_e'(i_mode);
    end

    // Clear outranks a clipping beat landing in S2 on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear_clip) begin
            o_clip       <= '0;
            o_clip_count <= '0;
        end else if (load2) begin
            o_clip <= o_clip | s1_clip;
            if ((|s1_clip) && (o_clip_count != '1)) o_clip_count <= o_clip_count + 1'b1;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        fmt_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_lane (
            .clk    (i_clk),
            .reset  (i_reset),
            .load1  (load1),
            .load2  (load2),
            .sample (i_data[k*IN_WIDTH +: IN_WIDTH]),
            .mode   (s1_mode),
            .clip   (s1_clip[k]),
            .data   (o_data[k*OUT_WIDTH +: OUT_WIDTH])
        );
    end

endmodule

// File: tb/tb_sample_format_converter.sv
// Bench: a 2-lane 16->8 converter with a 2-bit counter, and a 1-lane 8->8 converter, checked against an arithmetic model.
module tb_sample_format_converter;
    import sdr_fmt_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---- DUT A: CHANNELS=2, IN=16, OUT=8, CNT=2
    sample_format_converter_if #(.W(32)) a_in ();
    sample_format_converter_if #(.W(16)) a_out ();
    logic       a_rst, a_clear;
    logic [1:0] a_mode, a_clip, a_cnt;

    sample_format_converter #(.CHANNELS(2), .IN_WIDTH(16), .OUT_WIDTH(8), .CNT_WIDTH(2)) dut_a (
        .i_clk(clk), .i_reset(a_rst), .i_valid(a_in.valid), .o_ready(a_in.ready),
        .i_data(a_in.data), .i_mode(a_mode), .o_valid(a_out.valid), .i_ready(a_out.ready),
        .o_data(a_out.data), .o_clip(a_clip), .i_clear_clip(a_clear), .o_clip_count(a_cnt)
    );

    // ---- DUT B: CHANNELS=1, IN=8, OUT=8
    logic        b_rst, b_valid, b_oready, b_ovalid, b_iready, b_clear;
    logic [7:0]  b_data, b_odata;
    logic [1:0]  b_mode;
    logic [0:0]  b_clip;
    logic [15:0] b_cnt;

    sample_format_converter #(.CHANNELS(1), .IN_WIDTH(8), .OUT_WIDTH(8), .CNT_WIDTH(16)) dut_b (
        .i_clk(clk), .i_reset(b_rst), .i_valid(b_valid), .o_ready(b_oready),
        .i_data(b_data), .i_mode(b_mode), .o_valid(b_ovalid), .i_ready(b_iready),
        .o_data(b_odata), .o_clip(b_clip), .i_clear_clip(b_clear), .o_clip_count(b_cnt)
    );

    // ---- Scoreboards
    logic [15:0] a_q[$];
    logic [7:0]  b_q[$];
    bit          a_hold, b_hold, a_in_xfer;
    logic [15:0] a_hold_data;
    logic [7:0]  b_hold_data;
    logic [1:0]  a_clip_or;
    int          a_clip_beats, a_n_out;
    bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference conversion: round half up, saturate positive, then format map.
    function automatic int conv(input int s, input int mode, input int in_w, input int out_w, output bit clip);
        int d, t, v, maxv;
        d    = in_w - out_w;
        maxv = (1 << (out_w - 1)) - 1;
        if (d == 0) v = s;
        else begin
            t = s + (1 << (d - 1));
            v = (t >= 0) ? t / (1 << d) : -((-t + (1 << d) - 1) / (1 << d));
        end
        clip = v > maxv;
        if (clip) v = maxv;
        case (mode)
            1:       return v;
            2:       return (v < 0) ? -v : v;
            default: return v + (1 << (out_w - 1));
        endcase
    endfunction

    function automatic logic [15:0] rand_sample();
        logic [15:0] edges [7] = '{16'h7F7F, 16'h8000, 16'hFF80, 16'hFF7F, 16'h0080, 16'h007F, 16'h7FFF};
        case ($urandom_range(0, 3))
            0:       return 16'h7F80 + 16'($urandom_range(0, 127));
            1:       return edges[$urandom_range(0, 6)];
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic step_a(input bit v, input logic [31:0] d, input logic [1:0] m, input bit r, input bit clr);
        bit c0, c1;
        int e0, e1;
        @(negedge clk);
        a_in.valid = v; a_in.data = d; a_mode = m; a_out.ready = r; a_clear = clr;
        #1;
        if (a_hold) begin
            check("a_stall_valid", 32'(a_out.valid), 1);
            check("a_stall_data", 32'(a_out.data), 32'(a_hold_data));
        end
        if (a_out.valid && r) begin
            check("a_pop_nonempty", 32'(a_q.size() != 0), 1);
            if (a_q.size() != 0) check("a_data", 32'(a_out.data), 32'(a_q.pop_front()));
            a_n_out++;
        end
        a_hold      = a_out.valid && !r;
        a_hold_data = a_out.data;
        a_in_xfer   = v && a_in.ready;
        if (a_in_xfer) begin
            e0 = conv(int'($signed(d[15:0])), int'(m), 16, 8, c0);
            e1 = conv(int'($signed(d[31:16])), int'(m), 16, 8, c1);
            a_q.push_back({8'(e1), 8'(e0)});
            a_clip_or = a_clip_or | {c1, c0};
            if (c0 || c1) a_clip_beats++;
        end
    endtask

    task automatic step_b(input bit v, input logic [7:0] d, input logic [1:0] m, input bit r);
        bit c;
        int e;
        @(negedge clk);
        b_valid = v; b_data = d; b_mode = m; b_iready = r;
        #1;
        if (b_hold) check("b_stall_data", 32'(b_odata), 32'(b_hold_data));
        if (b_ovalid && r) begin
            check("b_pop_nonempty", 32'(b_q.size() != 0), 1);
            if (b_q.size() != 0) check("b_data", 32'(b_odata), 32'(b_q.pop_front()));
        end
        b_hold      = b_ovalid && !r;
        b_hold_data = b_odata;
        if (v && b_oready) begin
            e = conv(int'($signed(d)), int'(m), 8, 8, c);
            b_q.push_back(8'(e));
        end
    endtask

    task automatic reset_a();
        @(negedge clk);
        a_rst = 1'b1; a_in.valid = 1'b0; a_out.ready = 1'b0; a_clear = 1'b0;
        @(negedge clk);
        a_rst = 1'b0;
        a_q.delete(); a_hold = 1'b0; a_clip_or = '0; a_clip_beats = 0; a_n_out = 0;
        #1;
    endtask

    task automatic reset_b();
        @(negedge clk);
        b_rst = 1'b1; b_valid = 1'b0; b_iready = 1'b0;
        @(negedge clk);
        b_rst = 1'b0;
        b_q.delete(); b_hold = 1'b0;
        #1;
    endtask

    task automatic send_a(input string tag, input logic [31:0] d, input logic [1:0] m, input logic [7:0] exp);
        int n = 0;
        step_a(1'b1, d, m, 1'b1, 1'b0);
        do begin
            step_a(1'b0, '0, '0, 1'b1, 1'b0);
            n++;
        end while (!a_out.valid && n < 6);
        check({tag, "_latency"}, 32'(n), 2);
        check(tag, 32'(a_out.data[7:0]), 32'(exp));
    endtask

    task automatic send_b(input string tag, input logic [7:0] d, input logic [1:0] m, input logic [7:0] exp);
        int n = 0;
        step_b(1'b1, d, m, 1'b1);
        do begin
            step_b(1'b0, '0, '0, 1'b1);
            n++;
        end while (!b_ovalid && n < 6);
        check({tag, "_valid"}, 32'(b_ovalid), 1);
        check(tag, 32'(b_odata), 32'(exp));
    endtask

    initial begin
        int sent, cyc;
        a_rst = 1'b1; a_clear = 1'b0; a_mode = '0; a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
        b_rst = 1'b1; b_clear = 1'b0; b_mode = '0; b_valid = 1'b0; b_data = '0; b_iready = 1'b0;
        a_hold = 1'b0; b_hold = 1'b0; a_clip_or = '0; a_clip_beats = 0; a_n_out = 0;

        // Reset state
        reset_a();
        reset_b();
        check("a_rst_valid", 32'(a_out.valid), 0);
        check("a_rst_ready", 32'(a_in.ready), 1);
        check("a_rst_data", 32'(a_out.data), 0);
        check("a_rst_clip", 32'(a_clip), 0);
        check("a_rst_cnt", 32'(a_cnt), 0);
        check("b_rst_valid", 32'(b_ovalid), 0);

        // 8->8 offset-binary ramp, continuous, fixed 2-cycle latency
        for (int i = 0; i < 256; i++) begin
            step_b(1'b1, 8'(i - 128), FMT_OFFSET, 1'b1);
            check("b_ramp_valid", 32'(b_ovalid), 32'(i >= 2));
        end
        for (int i = 0; i < 3; i++) step_b(1'b0, '0, '0, 1'b1);
        check("b_ramp_drained", 32'(b_q.size()), 0);
        check("b_ramp_clip", 32'(b_clip), 0);
        check("b_ramp_cnt", 32'(b_cnt), 0);
        send_b("b_off_m1", 8'hFF, FMT_OFFSET, 8'd127);
        send_b("b_off_0", 8'h00, FMT_OFFSET, 8'd128);

        // Magnitude and pass-through
        send_b("b_mag_m128", 8'h80, FMT_MAG, 8'd128);
        send_b("b_mag_m5", 8'hFB, FMT_MAG, 8'd5);
        send_b("b_mag_7", 8'h07, FMT_MAG, 8'd7);
        send_b("b_twos_m5", 8'hFB, FMT_TWOS, 8'hFB);
        check("b_mag_noclip", 32'(b_clip), 0);

        // 16->8 rounding and saturation
        reset_a();
        send_a("a_sat_7fc0", 32'h0000_7FC0, FMT_OFFSET, 8'hFF);
        check("a_sat_clip", 32'(a_clip), 32'b01);
        check("a_sat_cnt", 32'(a_cnt), 1);
        send_a("a_rnd_0080", 32'h0000_0080, FMT_OFFSET, 8'h81);
        send_a("a_rnd_ff7f", 32'h0000_FF7F, FMT_OFFSET, 8'h7F);
        check("a_rnd_cnt", 32'(a_cnt), 1);

        // Stall pattern 1,0,0,1 with 10 beats and a changing mode
        reset_a();
        sent = 0;
        cyc  = 0;
        while ((sent < 10 || a_n_out < 10) && cyc < 100) begin
            step_a(sent < 10, {16'(sent * 517), 16'(sent * 4099 - 20000)}, 2'(sent % 3), pat[cyc % 4], 1'b0);
            if (a_in_xfer) sent++;
            cyc++;
        end
        check("a_stall_out_count", 32'(a_n_out), 10);
        check("a_stall_drained", 32'(a_q.size()), 0);

        // Reset with two beats in flight
        reset_a();
        step_a(1'b1, 32'h1234_7FF0, FMT_TWOS, 1'b1, 1'b0);
        step_a(1'b1, 32'h0100_0200, FMT_TWOS, 1'b1, 1'b0);
        reset_a();
        check("a_mid_rst_valid", 32'(a_out.valid), 0);
        check("a_mid_rst_clip", 32'(a_clip), 0);
        check("a_mid_rst_cnt", 32'(a_cnt), 0);
        check("a_mid_rst_ready", 32'(a_in.ready), 1);
        send_a("a_after_rst", 32'h0000_0180, FMT_TWOS, 8'h02);

        // Saturating counter and clear priority
        reset_a();
        for (int i = 0; i < 5; i++) begin
            send_a("a_cnt_beat", 32'h7FC0_0000, FMT_OFFSET, 8'h80);
            check("a_cnt_value", 32'(a_cnt), 32'((i + 1 > 3) ? 3 : i + 1));
        end
        check("a_cnt_clip_lane1", 32'(a_clip), 32'b10);
        step_a(1'b1, 32'h0000_7FFF, FMT_OFFSET, 1'b1, 1'b0);
        step_a(1'b0, '0, '0, 1'b1, 1'b1);
        step_a(1'b0, '0, '0, 1'b1, 1'b0);
        check("a_clr_cnt", 32'(a_cnt), 0);
        check("a_clr_clip", 32'(a_clip), 0);
        step_a(1'b0, '0, '0, 1'b1, 1'b0);
        check("a_clr_drained", 32'(a_q.size()), 0);

        // Randomized stream with random backpressure and modes
        reset_a();
        for (int i = 0; i < 400; i++) begin
            step_a($urandom_range(0, 3) != 0, {rand_sample(), rand_sample()}, 2'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0, 1'b0);
        end
        for (int i = 0; i < 4; i++) step_a(1'b0, '0, '0, 1'b1, 1'b0);
        check("a_rand_drained", 32'(a_q.size()), 0);
        check("a_rand_clip", 32'(a_clip), 32'(a_clip_or));
        check("a_rand_cnt", 32'(a_cnt), 32'((a_clip_beats > 3) ? 3 : a_clip_beats));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sample_format_converter.md
SAMPLE_FORMAT_CONVERTER -- requirements
Module: sample_format_converter

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of parallel sample lanes.
REQ-002 SHALL have parameter IN_WIDTH, default 16: signed input sample width.
REQ-003 SHALL have parameter OUT_WIDTH, default 8: output sample width; legal range 2..IN_WIDTH.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: clip event counter width.
REQ-005 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port i_valid, input, 1: input beat valid.
REQ-008 SHALL have port o_ready, output, 1: converter accepts the input beat this cycle.
REQ-009 SHALL have port i_data, input, CHANNELS*IN_WIDTH: two's-complement samples; lane k in bits [k*IN_WIDTH +: IN_WIDTH].
REQ-010 SHALL have port i_mode, input, 2: 0 offset-binary, 1 two's-complement pass, 2 unsigned magnitude, 3 reserved (treated as 0).
REQ-011 SHALL have port o_valid, output, 1: output beat valid.
REQ-012 SHALL have port i_ready, input, 1: downstream accepts the output beat.
REQ-013 SHALL have port o_data, output, CHANNELS*OUT_WIDTH: converted samples, same lane packing as i_data.
REQ-014 SHALL have port o_clip, output, CHANNELS: sticky per-lane saturation flags.
REQ-015 SHALL have port i_clear_clip, input, 1: clears o_clip and o_clip_count.
REQ-016 SHALL have port o_clip_count, output, CNT_WIDTH: saturating count of accepted beats with at least one clipped lane.

Function
REQ-017 An input beat SHALL transfer when i_valid and o_ready are both high; an output beat SHALL transfer when o_valid and i_ready are both high.
REQ-018 Pipeline SHALL be two register stages (S1 round/saturate, S2 format map); latency SHALL be 2 cycles from input transfer to o_valid with i_ready held high.
REQ-019 S2 load enable SHALL be en2 = i_ready | ~o_valid; S1 load enable en1 = en2 | ~s1_valid; o_ready SHALL equal en1 (combinational path from i_ready permitted).
REQ-020 Full throughput SHALL be one beat per cycle; under stall no beat SHALL be dropped or duplicated, and o_data SHALL stay stable while o_valid & ~i_ready.
REQ-021 i_mode SHALL be sampled with the beat at input transfer and carried with it; a mode change mid-stream affects only later beats.
REQ-022 Rounding for D = IN_WIDTH-OUT_WIDTH > 0: add 2^(D-1), arithmetic shift right by D (round half up); D = 0: no rounding.
REQ-023 Rounded value above 2^(OUT_WIDTH-1)-1 SHALL saturate to 2^(OUT_WIDTH-1)-1 and flag that lane as clipped; negative results cannot clip.
REQ-024 Mode 0 SHALL invert the MSB of the rounded value (value + 2^(OUT_WIDTH-1)); mode 1 SHALL pass it unchanged; mode 2 SHALL output |value| as unsigned (-2^(OUT_WIDTH-1) maps to 2^(OUT_WIDTH-1), no clip).
REQ-025 o_clip[k] SHALL set when a beat with lane k clipped enters S2, and hold until i_clear_clip or reset.
REQ-026 o_clip_count SHALL increment once per beat entering S2 with any lane clipped, saturating at all-ones.
REQ-027 i_clear_clip coinciding with a clipping beat SHALL take priority: flags and count read zero next cycle, and that beat's clip is lost.

Reset
REQ-028 On i_reset high at a clock edge: o_valid, internal s1_valid, o_clip and o_clip_count SHALL be 0; o_data SHALL be 0.
REQ-029 Reset mid-stream SHALL discard all in-flight beats; o_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 No beat SHALL transfer on a cycle where i_reset is high.

Structure
REQ-031 Mode encodings (FMT_OFFSET, FMT_TWOS, FMT_MAG) SHALL be constants in shared package sdr_fmt_pkg.
REQ-032 Per-lane round/saturate/map logic SHALL be sub-module fmt_lane, instantiated CHANNELS times by generate; handshake, clip flags and counter stay in the top.

Verification
REQ-033 IN=OUT=8, mode 0, ramp -128..127 continuous: outputs 0..255 two cycles later, -1->127, 0->128, no clip.
REQ-034 IN=16, OUT=8, mode 0: 0x7FC0 -> 0xFF with o_clip[0]=1, count=1; 0x0080 -> 0x81; 0xFF7F -> 0x7F.
REQ-035 Mode 2, IN=OUT=8: -128 -> 128, -5 -> 5, 7 -> 7; mode 1: -5 -> 0xFB.
REQ-036 Stream 10 beats with i_ready toggling 1,0,0,1 pattern: all 10 beats out in order, none lost or repeated, o_data stable during stalls.
REQ-037 Reset asserted with 2 beats in flight: o_valid=0 next cycle, o_clip=0, count=0, o_ready=1; later beats pass normally.
REQ-038 CNT_WIDTH=2, five clipping beats: count 1,2,3,3,3; i_clear_clip with a clipping beat -> count 0 and o_clip 0.
